rv_id_ctrl: RTL
===============

# rv_id_ctrl

Decode-stage controller for the RV64 core. It accepts fetched instructions from IF over a valid/ready handshake and buffers them in a 2-entry skid buffer. It expands each immediate at capture time through the existing `rv_imm_gen` instance. It presents a decoded packet to EX, applies a load-use interlock and discards contents on pipeline flush.

## Interface
- No parameters; XLEN fixed at 64.
- `clk_i` in 1: core clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `if_valid_i` in 1: IF offers an instruction.
- `if_instr_i` in 32: instruction word.
- `if_pc_i` in 64: PC of the instruction.
- `if_ready_o` out 1: ID can accept this cycle.
- `flush_i` in 1: redirect from EX; kill all buffered and incoming instructions.
- `ex_ready_i` in 1: EX accepts the ID packet.
- `ex_rd_i` in 5: destination register of the instruction currently in EX.
- `ex_memread_i` in 1: instruction in EX is a load.
- `id_valid_o` out 1: packet on `id_*` is valid and not interlocked.
- `id_instr_o` out 32: head instruction.
- `id_pc_o` out 64: head PC.
- `id_imm_o` out 64: head immediate, as expanded by `rv_imm_gen`.
- `id_rs1_o` out 5: `instr[19:15]`.
- `id_rs2_o` out 5: `instr[24:20]`.
- `id_rd_o` out 5: `instr[11:7]`.
- `hazard_o` out 1: load-use interlock active this cycle.

## Operation
- Storage: a head entry and a skid entry. Each entry holds instr, pc, imm, use_rs1 and use_rs2.
- `rv_imm_gen` is driven by `if_instr_i`. Its output is registered with the entry, so there is no combinational path from `if_instr_i` to `id_imm_o`.
- use_rs1 is 0 for opcodes 0110111, 0010111 and 1101111, and 1 otherwise.
- use_rs2 is 1 for opcodes 0110011, 0111011, 0100011 and 1100011, and 0 otherwise.
- FSM states:
  - EMPTY: no entries.
  - ONE: head only.
  - TWO: head and skid.
- Handshake signals:
  - `if_ready_o` = (state != TWO) && !rst_i.
  - in = `if_valid_i` && `if_ready_o` && !`flush_i`.
  - out = `id_valid_o` && `ex_ready_i`.
- Hazard: `hazard_o` = head valid && `ex_memread_i` && `ex_rd_i` != 0 && ((use_rs1 && rs1 == `ex_rd_i`) || (use_rs2 && rs2 == `ex_rd_i`)).
- `id_valid_o` = head valid && !`hazard_o`.
- Transitions:
  - EMPTY: in moves to ONE.
  - ONE:
    - in && !out moves to TWO; the new instruction goes to skid.
    - in && out stays ONE; head is replaced by the new instruction.
    - !in && out moves to EMPTY.
  - TWO:
    - out moves to ONE; skid moves to head.
    - No input is accepted in TWO.
- Flush has priority over everything:
  - Next state is EMPTY.
  - The incoming instruction in the same cycle is dropped, even if `if_ready_o` = 1.
  - An out transfer in the flush cycle still completes; EX is responsible for killing it.
- Ordering is strictly FIFO. No instruction is duplicated or reordered.
- While an instruction is in the head, `id_*` data outputs hold stable until out occurs.

## Timing
- Reset values:
  - State EMPTY.
  - `id_valid_o` = 0 and `hazard_o` = 0.
  - `id_instr_o`, `id_pc_o`, `id_imm_o`, `id_rs1_o`, `id_rs2_o` and `id_rd_o` are all 0; entry registers are cleared.
  - `if_ready_o` = 0 while `rst_i` is high.
  - `if_ready_o` = 1 in the first cycle after `rst_i` drops.
- Latency: an instruction accepted at edge N is on `id_*` with `id_valid_o` = 1 after edge N, i.e. 1 cycle.
- Throughput: 1 instruction per cycle while `ex_ready_i` = 1 and no hazard.
- `hazard_o` and `id_valid_o` are combinational from `ex_rd_i`, `ex_memread_i` and the head registers. This is the only comb path from inputs to outputs besides `if_ready_o` from `rst_i`.
- Flush takes effect at the next edge: `id_valid_o` = 0 in the cycle after `flush_i`.
- Reset mid-operation discards both entries at the next edge.

## Configuration
- Macro `RV_ID_LOAD_USE_INTERLOCK_EN`.
- Defined: hazard logic is as above.
- Undefined: `hazard_o` is tied to 0, `id_valid_o` = head valid, and the use_rs1/use_rs2 storage is removed. Forwarding or software is then responsible for load-use hazards.

## Test plan
- Reset then stream: hold `ex_ready_i` = 1 and feed `addi x1,x0,-5` (0xFFB00093) at PC 0x1000.
  - Next cycle: `id_valid_o` = 1, `id_imm_o` = 0xFFFFFFFFFFFFFFFB, `id_rd_o` = 1.
- Back-pressure: feed 3 consecutive instructions with `ex_ready_i` = 0.
  - The first two are accepted.
  - `if_ready_o` = 0 from the cycle after the second acceptance.
  - Raise `ex_ready_i`: all three emerge in order, with no loss or duplication.
- Load-use: set `ex_memread_i` = 1 and `ex_rd_i` = 5, with `add x6,x5,x7` in the head.
  - `hazard_o` = 1 and `id_valid_o` = 0; the packet is held.
  - Drop `ex_memread_i`: `id_valid_o` = 1 with the same PC.
  - Repeat with `lui x5` in the head: no hazard.
  - Repeat with `ex_rd_i` = 0: no hazard.
- Flush: reach TWO, then pulse `flush_i` with `if_valid_i` = 1.
  - Next cycle: `id_valid_o` = 0, `if_ready_o` = 1.
  - The concurrent instruction never appears on `id_*`.
- Immediate forms: check one instruction per form.
  - `sd` with offset -8 gives 0xFFFFFFFFFFFFFFF8.
  - `beq` with offset +16 gives 0x10.
  - `jal` with offset -4 gives 0xFFFFFFFFFFFFFFFC.
  - `slli` with shamt 33 gives 0x21.
- Mid-stream reset: assert `rst_i` while in TWO.
  - All outputs read their reset values after the edge.
  - No stale instruction appears after reset releases.

Source files
------------

// File: rtl/rv_id_ctrl.sv
// Decode-stage controller for the RV64 core.
// A 2-entry skid buffer (head + skid) sits between IF and EX. Immediates are
// expanded by rv_imm_gen as instructions are captured, so id_imm_o is driven
// straight from a register. The load-use interlock is built only when the
// macro RV_ID_LOAD_USE_INTERLOCK_EN is defined; without it hazard_o is tied
// low and operand-use bits are not stored.

// RV64 immediate expander, purely combinational, selected by the major opcode.
module rv_imm_gen (
    input  logic [31:0] instr_i,
    output logic [63:0] imm_o
);

    // Pick the immediate layout from the opcode and sign-extend it to 64 bits.
    always_comb begin
        // NOTE: give every always_comb output a value before any branch so no
        // path can leave it unassigned and infer a latch.
        imm_o = '0;
        case (instr_i[6:0])
            // I-type: loads, OP-IMM, OP-IMM-32, JALR, SYSTEM
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011:
                imm_o = {{52{instr_i[31]}}, instr_i[31:20]};
            // S-type: stores
            7'b0100011:
                imm_o = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            // B-type: branches
            7'b1100011:
                imm_o = {{51{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            // U-type: LUI, AUIPC
            7'b0110111, 7'b0010111:
                imm_o = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
            // J-type: JAL
            7'b1101111:
                imm_o = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            default:
                imm_o = '0;
        endcase
    end

endmodule

module rv_id_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_valid_i,
    input  logic [31:0] if_instr_i,
    input  logic [63:0] if_pc_i,
    output logic        if_ready_o,
    input  logic        flush_i,
    input  logic        ex_ready_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_memread_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [63:0] id_pc_o,
    output logic [63:0] id_imm_o,
    output logic [4:0]  id_rs1_o,
    output logic [4:0]  id_rs2_o,
    output logic [4:0]  id_rd_o,
    output logic        hazard_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
`ifdef RV_ID_LOAD_USE_INTERLOCK_EN
        logic        use_rs1;
        logic        use_rs2;
`endif
    } entry_t;

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic [63:0] in_imm;
    logic        head_valid;
    logic        in_xfer;
    logic        out_xfer;

    rv_imm_gen u_imm_gen (
        .instr_i (if_instr_i),
        .imm_o   (in_imm)
    );

    // Package the incoming instruction as a buffer entry.
    always_comb begin
        in_entry       = '0;
        in_entry.instr = if_instr_i;
        in_entry.pc    = if_pc_i;
        in_entry.imm   = in_imm;
`ifdef RV_ID_LOAD_USE_INTERLOCK_EN
        // LUI, AUIPC and JAL carry no rs1; only R/R32, store and branch read rs2.
        in_entry.use_rs1 = !(if_instr_i[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
        in_entry.use_rs2 = if_instr_i[6:0] inside {7'b0110011, 7'b0111011,
                                                   7'b0100011, 7'b1100011};
`endif
    end

    assign head_valid = (state_q != ST_EMPTY);
    assign if_ready_o = (state_q != ST_TWO) && !rst_i;
    assign in_xfer    = if_valid_i && if_ready_o && !flush_i;

`ifdef RV_ID_LOAD_USE_INTERLOCK_EN
    assign hazard_o = head_valid && ex_memread_i && (ex_rd_i != 5'd0) &&
                      ((head_q.use_rs1 && (head_q.instr[19:15] == ex_rd_i)) ||
                       (head_q.use_rs2 && (head_q.instr[24:20] == ex_rd_i)));
`else
    // Load-use is resolved elsewhere; the EX hint inputs are intentionally unused.
    logic unused_ex;
    assign unused_ex = ^{ex_rd_i, ex_memread_i};
    assign hazard_o  = 1'b0;
`endif

    assign id_valid_o = head_valid && !hazard_o;
    assign out_xfer   = id_valid_o && ex_ready_i;

    // Next state and entry contents from the in/out handshakes; flush wins last.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d = ST_ONE;
                    head_d  = in_entry;
                end
            end
            ST_ONE: begin
                if (in_xfer && !out_xfer) begin
                    state_d = ST_TWO;
                    skid_d  = in_entry;
                end else if (in_xfer && out_xfer) begin
                    head_d  = in_entry;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_xfer) begin
                    state_d = ST_ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // in_xfer is already masked by flush, so only the state needs forcing;
        // an out transfer in this cycle still completes toward EX.
        if (flush_i) begin
            state_d = ST_EMPTY;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Head and skid entry registers.
    always_ff @(posedge clk_i) begin
        // NOTE: data storage is normally left unreset; these two entries are
        // cleared because id_* must read zero straight out of reset.
        if (rst_i) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

    assign id_instr_o = head_q.instr;
    assign id_pc_o    = head_q.pc;
    assign id_imm_o   = head_q.imm;
    assign id_rs1_o   = head_q.instr[19:15];
    assign id_rs2_o   = head_q.instr[24:20];
    assign id_rd_o    = head_q.instr[11:7];

endmodule
